// File: rtl/handshake_loop_sequencer.sv
// Loop sequencer: a start token begins a run of N indexed control tokens, then one done token.
// Define HANDSHAKE_LOOP_SEQ_STALL_CNT_EN to add the stall_cycles backpressure counter.
module handshake_loop_sequencer #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [CNT_WIDTH-1:0] start_count,
    output logic                 ctrl_valid,
    input  logic                 ctrl_ready,
    output logic [CNT_WIDTH-1:0] ctrl_idx,
    output logic                 ctrl_last,
    output logic                 done_valid,
    input  logic                 done_ready
`ifdef HANDSHAKE_LOOP_SEQ_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_t               r_state;
    state_t               w_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_idx;
    logic                 w_last;
    logic                 w_start_hs;
    logic                 w_ctrl_hs;

    assign w_last     = (r_state == RUN) && (r_idx == (r_cnt - ONE));
    assign w_start_hs = start_valid && (r_state == IDLE);
    assign w_ctrl_hs  = ctrl_ready && (r_state == RUN);
    assign ctrl_idx   = r_idx;
    assign ctrl_last  = w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        start_ready = 1'b0;
        ctrl_valid  = 1'b0;
        done_valid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    w_next = (start_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                ctrl_valid = 1'b1;
                if (ctrl_ready && w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // idx stops at count-1, so it can never wrap even at the maximum count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_start_hs) begin
            r_cnt <= start_count;
            r_idx <= '0;
        end else if (w_ctrl_hs && !w_last) begin
            r_idx <= r_idx + ONE;
        end
    end

`ifdef HANDSHAKE_LOOP_SEQ_STALL_CNT_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst || w_start_hs) begin
            r_stall <= '0;
        end else if ((r_state == RUN) && !ctrl_ready && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_handshake_loop_sequencer.sv
// Bench for handshake_loop_sequencer: vector table, hand-written corner runs,
// then randomized runs checked against a token-sequence reference model.
module tb_handshake_loop_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] start_count;
    logic         ctrl_valid;
    logic         ctrl_ready;
    logic [W-1:0] ctrl_idx;
    logic         ctrl_last;
    logic         done_valid;
    logic         done_ready;
`ifdef HANDSHAKE_LOOP_SEQ_STALL_CNT_EN
    logic [31:0]  stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    handshake_loop_sequencer #(.CNT_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_count (start_count),
        .ctrl_valid  (ctrl_valid),
        .ctrl_ready  (ctrl_ready),
        .ctrl_idx    (ctrl_idx),
        .ctrl_last   (ctrl_last),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
`ifdef HANDSHAKE_LOOP_SEQ_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic         rst;
        logic         sv;
        logic [W-1:0] sc;
        logic         cr;
        logic         dr;
        logic         e_sr;
        logic         e_cv;
        logic [W-1:0] e_idx;
        logic         e_last;
        logic         e_dv;
        logic         chk;
        logic         chk_idx;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic r, input logic sv, input int sc, input logic cr, input logic dr,
        input logic sr, input logic cv, input int idx, input logic lst, input logic dv,
        input logic c, input logic ci);
        vec_t v;
        v.rst = r; v.sv = sv; v.sc = W'(sc); v.cr = cr; v.dr = dr;
        v.e_sr = sr; v.e_cv = cv; v.e_idx = W'(idx); v.e_last = lst; v.e_dv = dv;
        v.chk = c; v.chk_idx = ci;
        return v;
    endfunction

    // random-run reference data
    int tok_idx[$];
    int tok_last[$];

    initial begin
        rst = 1'b1; start_valid = 1'b0; start_count = '0;
        ctrl_ready = 1'b0; done_ready = 1'b0;

        // inputs for this cycle | outputs expected during this cycle
        vt.push_back(mk(1,0,0,0,0, 0,0,0,0,0, 0,0));
        vt.push_back(mk(0,1,3,1,1, 1,0,0,0,0, 1,1)); // reset state, start 3
        vt.push_back(mk(0,0,0,1,1, 0,1,0,0,0, 1,1));
        vt.push_back(mk(0,0,0,1,1, 0,1,1,0,0, 1,1));
        vt.push_back(mk(0,0,0,1,1, 0,1,2,1,0, 1,1));
        vt.push_back(mk(0,0,0,1,1, 0,0,0,0,1, 1,0)); // done one cycle
        vt.push_back(mk(0,1,0,1,1, 1,0,0,0,0, 1,0)); // start 0
        vt.push_back(mk(0,0,0,1,1, 0,0,0,0,1, 1,0));
        vt.push_back(mk(0,1,2,0,1, 1,0,0,0,0, 1,0)); // start 2
        vt.push_back(mk(0,0,0,0,1, 0,1,0,0,0, 1,1));
        vt.push_back(mk(0,0,0,0,1, 0,1,0,0,0, 1,1));
        vt.push_back(mk(0,0,0,0,1, 0,1,0,0,0, 1,1));
        vt.push_back(mk(0,0,0,0,1, 0,1,0,0,0, 1,1));
        vt.push_back(mk(0,0,0,1,1, 0,1,0,0,0, 1,1));
        vt.push_back(mk(0,0,0,1,1, 0,1,1,1,0, 1,1));
        vt.push_back(mk(0,0,0,1,1, 0,0,0,0,1, 1,0)); // index 15: 4 stalls seen
        vt.push_back(mk(0,1,5,1,1, 1,0,0,0,0, 1,0)); // start 5
        vt.push_back(mk(0,0,0,1,1, 0,1,0,0,0, 1,1));
        vt.push_back(mk(0,1,7,1,1, 0,1,1,0,0, 1,1)); // ignored start
        vt.push_back(mk(0,0,0,1,1, 0,1,2,0,0, 1,1));
        vt.push_back(mk(1,0,0,1,1, 0,1,3,0,0, 1,1)); // reset mid-run
        vt.push_back(mk(0,0,0,1,1, 1,0,0,0,0, 1,1));
        vt.push_back(mk(0,0,0,0,1, 1,0,0,0,0, 1,1)); // no done token

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            rst = vt[i].rst; start_valid = vt[i].sv; start_count = vt[i].sc;
            ctrl_ready = vt[i].cr; done_ready = vt[i].dr;
            if (vt[i].chk) begin
                check($sformatf("v%0d start_ready", i), 32'(start_ready), 32'(vt[i].e_sr));
                check($sformatf("v%0d ctrl_valid", i), 32'(ctrl_valid), 32'(vt[i].e_cv));
                check($sformatf("v%0d ctrl_last", i), 32'(ctrl_last), 32'(vt[i].e_last));
                check($sformatf("v%0d done_valid", i), 32'(done_valid), 32'(vt[i].e_dv));
                if (vt[i].chk_idx)
                    check($sformatf("v%0d ctrl_idx", i), 32'(ctrl_idx), 32'(vt[i].e_idx));
            end
`ifdef HANDSHAKE_LOOP_SEQ_STALL_CNT_EN
            if (i == 15) check("stall_cycles", stall_cycles, 32'd4);
`endif
        end

        // maximum count with done backpressure
        @(negedge clk);
        rst = 1'b0; start_valid = 1'b1; start_count = W'(15);
        ctrl_ready = 1'b1; done_ready = 1'b0;
        check("max start_ready", 32'(start_ready), 32'd1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            start_valid = 1'b0;
            check($sformatf("max cv %0d", i), 32'(ctrl_valid), 32'd1);
            check($sformatf("max idx %0d", i), 32'(ctrl_idx), 32'(i));
            check($sformatf("max last %0d", i), 32'(ctrl_last), 32'(i == 14));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_valid = 1'b1;
            check($sformatf("max dv hold %0d", i), 32'(done_valid), 32'd1);
            check($sformatf("max sr hold %0d", i), 32'(start_ready), 32'd0);
        end
        @(negedge clk);
        start_valid = 1'b0; done_ready = 1'b1;
        check("max dv final", 32'(done_valid), 32'd1);
        @(negedge clk);
        done_ready = 1'b0;
        check("max idle sr", 32'(start_ready), 32'd1);
        check("max idle dv", 32'(done_valid), 32'd0);

        // randomized runs against token-sequence model
        for (int r = 0; r < 40; r++) begin
            int n, k, cst, dst, prev_idx;
            bit done, stalled;
            n = int'($urandom_range(0, 15));
            tok_idx.delete();
            tok_last.delete();
            @(negedge clk);
            check($sformatf("r%0d idle sr", r), 32'(start_ready), 32'd1);
            check($sformatf("r%0d idle cv", r), 32'(ctrl_valid | done_valid), 32'd0);
            start_valid = 1'b1; start_count = W'(n);
            ctrl_ready = 1'($urandom_range(0, 1));
            done_ready = 1'($urandom_range(0, 1));
            k = 0; cst = 0; dst = 0; done = 0; stalled = 0; prev_idx = 0;
            while (!done && k < 300) begin
                @(negedge clk);
                k++;
                ctrl_ready = ($urandom_range(0, 3) != 0);
                done_ready = 1'($urandom_range(0, 1));
                start_valid = 1'($urandom_range(0, 1));
                start_count = W'($urandom);
                check($sformatf("r%0d busy sr", r), 32'(start_ready), 32'd0);
                check($sformatf("r%0d one valid", r), 32'(ctrl_valid ^ done_valid), 32'd1);
                if (stalled) begin
                    check($sformatf("r%0d hold cv", r), 32'(ctrl_valid), 32'd1);
                    check($sformatf("r%0d hold idx", r), 32'(ctrl_idx), 32'(prev_idx));
                end
                stalled = 0;
                if (ctrl_valid) begin
                    if (ctrl_ready) begin
                        tok_idx.push_back(int'(ctrl_idx));
                        tok_last.push_back(int'(ctrl_last));
                    end else begin
                        cst++;
                        stalled = 1;
                        prev_idx = int'(ctrl_idx);
                    end
                end else if (done_valid) begin
                    if (done_ready) done = 1;
                    else dst++;
                end
            end
            if (!done) begin
                errors++;
                $display("FAIL r%0d timeout waiting for done handshake", r);
            end
`ifdef HANDSHAKE_LOOP_SEQ_STALL_CNT_EN
            check($sformatf("r%0d stall_cycles", r), stall_cycles, 32'(cst));
`endif
            check($sformatf("r%0d token count", r), 32'(tok_idx.size()), 32'(n));
            for (int t = 0; t < tok_idx.size(); t++) begin
                check($sformatf("r%0d tok%0d idx", r, t), 32'(tok_idx[t]), 32'(t));
                check($sformatf("r%0d tok%0d last", r, t), 32'(tok_last[t]), 32'(t == n - 1));
            end
            check($sformatf("r%0d latency", r), 32'(k), 32'(n + cst + dst + 1));
            start_valid = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
